// File: rtl/forth_seq.sv
// Fetch/decode sequencer for the 16-bit stack CPU: owns the PC, decodes ROM words
// into tos_comb/tos_mem strobes and stack requests. Optional macro: SEQ_STACK_CHECK_EN.
module forth_seq #(
  parameter int width       = 16,
  parameter int iaddr_width = 13,
  parameter int RESET_PC    = 0,
  parameter int PDEPTH      = 16,
  parameter int RDEPTH      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  output logic                   halted,
  output logic [iaddr_width-1:0] iaddr,
  input  logic [width-1:0]       instr,
  input  logic [width-1:0]       TOS,
  input  logic                   TOS_is_zero,
  input  logic [width-1:0]       rstack_top,
  output logic [width-1:0]       imm,
  output logic                   rstack_sel,
  output logic                   zero_arg,
  output logic [1:0]             logic_op,
  output logic                   sub,
  output logic                   adder_sel,
  output logic                   shift_sel,
  output logic                   zero_sel,
  output logic                   reg_sel,
  output logic                   imm_sel,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   pstack_push,
  output logic                   pstack_pop,
  output logic                   rstack_push,
  output logic                   rstack_pop,
  output logic [width-1:0]       rstack_din,
  output logic                   fault
);

  localparam logic [1:0] S_HALT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  logic [1:0]             r_state;
  logic [iaddr_width-1:0] r_pc;
  logic [iaddr_width-1:0] w_pc_inc;
  logic [iaddr_width-1:0] w_pc_next;
  logic [iaddr_width-1:0] w_target;
  logic                   w_p_push;
  logic                   w_p_pop;
  logic                   w_r_push;
  logic                   w_r_pop;
  logic                   w_fault_now;
  logic                   w_start_ok;
  logic                   w_unused;

  assign halted   = (r_state == S_HALT);
  assign iaddr    = r_pc;
  assign w_pc_inc = r_pc + 1'b1;
  assign w_target = instr[iaddr_width-1:0];

  always_comb begin
    // NOTE: every output gets a default first so no path through the decode infers a latch.
    imm        = '0;
    rstack_sel = 1'b0;
    zero_arg   = 1'b0;
    logic_op   = 2'b00;
    sub        = 1'b0;
    adder_sel  = 1'b0;
    shift_sel  = 1'b0;
    zero_sel   = 1'b0;
    reg_sel    = 1'b0;
    imm_sel    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    w_p_push   = 1'b0;
    w_p_pop    = 1'b0;
    w_r_push   = 1'b0;
    w_r_pop    = 1'b0;
    rstack_din = '0;
    w_pc_next  = w_pc_inc;

    if (r_state != S_EXEC) begin
      // HOLD (TOS | 0) lets a pending memory read land in TOS_r after @.
      zero_arg = 1'b1;
      logic_op = 2'b01;
    end else if (instr[15]) begin
      imm      = width'(instr[14:0]);
      imm_sel  = 1'b1;
      w_p_push = 1'b1;
    end else begin
      case (instr[14:13])
        2'b00: begin
          zero_arg  = 1'b1;
          logic_op  = 2'b01;
          w_pc_next = w_target;
        end
        2'b01: begin
          reg_sel = 1'b1;
          w_p_pop = 1'b1;
          if (TOS_is_zero) w_pc_next = w_target;
        end
        2'b10: begin
          zero_arg   = 1'b1;
          logic_op   = 2'b01;
          w_r_push   = 1'b1;
          rstack_din = width'(w_pc_inc);
          w_pc_next  = w_target;
        end
        default: begin
          case (instr[11:8])
            4'd1:  reg_sel = 1'b1;
            4'd2:  begin reg_sel = 1'b1; rstack_sel = 1'b1; end
            4'd3:  adder_sel = 1'b1;
            4'd4:  begin adder_sel = 1'b1; sub = 1'b1; end
            4'd5:  logic_op = 2'b00;
            4'd6:  logic_op = 2'b01;
            4'd7:  logic_op = 2'b10;
            4'd8:  logic_op = 2'b11;
            4'd9:  shift_sel = 1'b1;
            4'd10: begin zero_sel = 1'b1; logic_op = 2'b11; end
            4'd11: begin zero_arg = 1'b1; logic_op = 2'b01; mem_read = 1'b1; end
            4'd12: begin mem_write = 1'b1; reg_sel = 1'b1; end
            default: begin zero_arg = 1'b1; logic_op = 2'b01; end
          endcase

          case (instr[7:6])
            2'b01:   w_p_push = 1'b1;
            2'b10:   w_p_pop  = 1'b1;
            default: ;
          endcase

          // Return overrides the rstack delta so push and pop never collide.
          if (instr[12]) begin
            w_r_pop   = 1'b1;
            w_pc_next = rstack_top[iaddr_width-1:0];
          end else begin
            case (instr[5:4])
              2'b01:   w_r_push = 1'b1;
              2'b10:   w_r_pop  = 1'b1;
              default: ;
            endcase
          end

          if (instr[3]) rstack_din = TOS;
        end
      endcase
    end
  end

`ifdef SEQ_STACK_CHECK_EN
  localparam int PD_W = $clog2(PDEPTH + 1);
  localparam int RD_W = $clog2(RDEPTH + 1);

  logic [PD_W-1:0] r_pdepth;
  logic [RD_W-1:0] r_rdepth;
  logic            r_fault;
  logic            w_p_ovf;
  logic            w_p_unf;
  logic            w_r_ovf;
  logic            w_r_unf;

  assign w_p_ovf = w_p_push && (r_pdepth == PD_W'(PDEPTH));
  assign w_p_unf = w_p_pop  && (r_pdepth == '0);
  assign w_r_ovf = w_r_push && (r_rdepth == RD_W'(RDEPTH));
  assign w_r_unf = w_r_pop  && (r_rdepth == '0);

  assign pstack_push = w_p_push & ~w_p_ovf;
  assign pstack_pop  = w_p_pop  & ~w_p_unf;
  assign rstack_push = w_r_push & ~w_r_ovf;
  assign rstack_pop  = w_r_pop  & ~w_r_unf;

  assign w_fault_now = w_p_ovf | w_p_unf | w_r_ovf | w_r_unf;
  assign w_start_ok  = ~r_fault;
  assign fault       = r_fault;
  assign w_unused    = ^rstack_top[width-1:iaddr_width];

  // Stack requests only exist in EXEC, so depth tracking follows the gated strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pdepth <= '0;
      r_rdepth <= '0;
      r_fault  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_pdepth <= r_pdepth + PD_W'(pstack_push) - PD_W'(pstack_pop);
      r_rdepth <= r_rdepth + RD_W'(rstack_push) - RD_W'(rstack_pop);
      if (w_fault_now) r_fault <= 1'b1;
    end
  end
`else
  assign pstack_push = w_p_push;
  assign pstack_pop  = w_p_pop;
  assign rstack_push = w_r_push;
  assign rstack_pop  = w_r_pop;
  assign w_fault_now = 1'b0;
  assign w_start_ok  = 1'b1;
  assign fault       = 1'b0;
  assign w_unused    = ^{rstack_top[width-1:iaddr_width], PDEPTH[0], RDEPTH[0]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_HALT;
      r_pc    <= iaddr_width'(RESET_PC);
    end else begin
      case (r_state)
        S_HALT:  if (run && w_start_ok) r_state <= S_FETCH;
        S_FETCH: r_state <= S_EXEC;
        S_EXEC: begin
          if (w_fault_now) begin
            r_state <= S_HALT;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= run ? S_FETCH : S_HALT;
          end
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_forth_seq.sv
// Directed bench for forth_seq: a registered ROM model feeds a hand-written program
// and each FETCH/EXEC cycle is compared against hand-computed strobes.
module tb_forth_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        halted;
  logic [12:0] iaddr;
  logic [15:0] instr = 16'h6000;
  logic [15:0] TOS;
  logic        TOS_is_zero;
  logic [15:0] rstack_top;
  logic [15:0] imm;
  logic        rstack_sel, zero_arg, sub, adder_sel, shift_sel, zero_sel;
  logic        reg_sel, imm_sel, mem_read, mem_write;
  logic [1:0]  logic_op;
  logic        pstack_push, pstack_pop, rstack_push, rstack_pop;
  logic [15:0] rstack_din;
  logic        fault;

  logic [15:0] rom [0:8191];
  logic [11:0] ctl;
  logic [3:0]  stk;

  int errors = 0;
  int checks = 0;

  // ctl bits: rstack_sel zero_arg logic_op[1:0] sub adder shift zero reg imm_sel mem_read mem_write
  localparam logic [11:0] C_HOLD = 12'h500;
  localparam logic [11:0] C_LIT  = 12'h004;
  localparam logic [11:0] C_REG  = 12'h008;
  localparam logic [11:0] C_ADD  = 12'h040;
  localparam logic [11:0] C_SUB  = 12'h0C0;
  localparam logic [11:0] C_ZEQ  = 12'h310;
  localparam logic [11:0] C_INV  = 12'h300;
  localparam logic [11:0] C_LOAD = 12'h502;

  assign ctl = {rstack_sel, zero_arg, logic_op, sub, adder_sel, shift_sel,
                zero_sel, reg_sel, imm_sel, mem_read, mem_write};
  assign stk = {pstack_push, pstack_pop, rstack_push, rstack_pop};

  forth_seq dut (
    .clk(clk), .reset(reset), .run(run), .halted(halted), .iaddr(iaddr),
    .instr(instr), .TOS(TOS), .TOS_is_zero(TOS_is_zero), .rstack_top(rstack_top),
    .imm(imm), .rstack_sel(rstack_sel), .zero_arg(zero_arg), .logic_op(logic_op),
    .sub(sub), .adder_sel(adder_sel), .shift_sel(shift_sel), .zero_sel(zero_sel),
    .reg_sel(reg_sel), .imm_sel(imm_sel), .mem_read(mem_read), .mem_write(mem_write),
    .pstack_push(pstack_push), .pstack_pop(pstack_pop), .rstack_push(rstack_push),
    .rstack_pop(rstack_pop), .rstack_din(rstack_din), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) instr <= rom[iaddr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) rom[i] = 16'h6000;
    rom[13'h0000] = 16'h8005;  // LIT 5
    rom[13'h0001] = 16'h0010;  // JMP 0x10
    rom[13'h0010] = 16'h2040;  // 0BRANCH 0x40, taken
    rom[13'h0040] = 16'h8001;  // LIT 1
    rom[13'h0041] = 16'h2050;  // 0BRANCH 0x50, not taken
    rom[13'h0042] = 16'h0007;  // JMP 7
    rom[13'h0007] = 16'h4100;  // CALL 0x100
    rom[13'h0100] = 16'h7000;  // ret
    rom[13'h0008] = 16'h6340;  // + d+1
    rom[13'h0009] = 16'h6498;  // - d-1 r+1 T->R
    rom[13'h000A] = 16'h6A20;  // 0= r-1
    rom[13'h000B] = 16'h6800;  // ~T
    rom[13'h000C] = 16'h6B00;  // @
    rom[13'h000D] = 16'h6100;  // N
    rom[13'h000E] = 16'h1FFF;  // JMP 0x1FFF
    rom[13'h1FFF] = 16'hFFFF;  // LIT 0x7FFF, pc wraps to 0

    reset = 1'b1; run = 1'b0; TOS = 16'h0000; TOS_is_zero = 1'b0; rstack_top = 16'h0000;
    #2;
    check("rst_halted", halted, 1'b1);
    check("rst_iaddr", iaddr, 13'h0000);
    check("rst_ctl", ctl, C_HOLD);
    check("rst_stk", stk, 4'b0000);
    check("rst_fault", fault, 1'b0);

    tick(); tick();
    reset = 1'b0; run = 1'b1;
    tick();
    check("f0_iaddr", iaddr, 13'h0000);
    check("f0_halted", halted, 1'b0);
    check("f0_ctl", ctl, C_HOLD);
    tick();
    check("lit_imm", imm, 16'h0005);
    check("lit_ctl", ctl, C_LIT);
    check("lit_stk", stk, 4'b1000);
    tick();
    check("f1_iaddr", iaddr, 13'h0001);
    tick();
    check("jmp_ctl", ctl, C_HOLD);
    check("jmp_stk", stk, 4'b0000);
    tick();
    check("jmp_iaddr", iaddr, 13'h0010);
    check("jmp_fetch_ctl", ctl, C_HOLD);
    TOS_is_zero = 1'b1;
    tick();
    check("zbr_t_ctl", ctl, C_REG);
    check("zbr_t_stk", stk, 4'b0100);
    tick();
    check("zbr_t_iaddr", iaddr, 13'h0040);
    TOS_is_zero = 1'b0;
    tick(); tick();
    check("lit1_iaddr", iaddr, 13'h0041);
    tick();
    check("zbr_n_ctl", ctl, C_REG);
    check("zbr_n_stk", stk, 4'b0100);
    tick();
    check("zbr_n_iaddr", iaddr, 13'h0042);
    tick(); tick();
    check("jmp7_iaddr", iaddr, 13'h0007);
    tick();
    check("call_stk", stk, 4'b0010);
    check("call_din", rstack_din, 16'h0008);
    check("call_ctl", ctl, C_HOLD);
    tick();
    check("call_iaddr", iaddr, 13'h0100);
    rstack_top = 16'hE008;
    tick();
    check("ret_stk", stk, 4'b0001);
    check("ret_ctl", ctl, C_HOLD);
    tick();
    check("ret_iaddr", iaddr, 13'h0008);
    TOS = 16'h1234;
    tick();
    check("add_ctl", ctl, C_ADD);
    check("add_stk", stk, 4'b1000);
    tick(); tick();
    check("sub_ctl", ctl, C_SUB);
    check("sub_stk", stk, 4'b0110);
    check("sub_tr_din", rstack_din, 16'h1234);
    tick(); tick();
    check("zeq_ctl", ctl, C_ZEQ);
    check("zeq_stk", stk, 4'b0001);
    tick(); tick();
    check("inv_ctl", ctl, C_INV);
    tick();
    check("ld_iaddr", iaddr, 13'h000C);
    tick();
    check("ld_ctl", ctl, C_LOAD);
    run = 1'b0;
    tick();
    check("halt_halted", halted, 1'b1);
    check("halt_ctl", ctl, C_HOLD);
    check("halt_iaddr", iaddr, 13'h000D);
    tick();
    check("halt_stay", halted, 1'b1);
    run = 1'b1;
    tick();
    check("resume_iaddr", iaddr, 13'h000D);
    run = 1'b0;
    tick();
    check("late_halt_exec", halted, 1'b0);
    check("n_ctl", ctl, C_REG);
    tick();
    check("late_halt", halted, 1'b1);
    check("late_halt_iaddr", iaddr, 13'h000E);
    run = 1'b1;
    tick(); tick();
    check("jmpmax_ctl", ctl, C_HOLD);
    tick();
    check("jmpmax_iaddr", iaddr, 13'h1FFF);
    tick();
    check("litmax_imm", imm, 16'h7FFF);
    check("litmax_stk", stk, 4'b1000);
    tick();
    check("wrap_iaddr", iaddr, 13'h0000);
    tick();
    check("lit_again_imm", imm, 16'h0005);
    reset = 1'b1;
    #1;
    check("rst_exec_halted", halted, 1'b1);
    check("rst_exec_stk", stk, 4'b0000);
    check("rst_exec_ctl", ctl, C_HOLD);
    check("rst_exec_imm", imm, 16'h0000);
    check("rst_exec_iaddr", iaddr, 13'h0000);

`ifdef SEQ_STACK_CHECK_EN
    rom[13'h0000] = 16'h6080;  // DROP with an empty pstack
    tick();
    reset = 1'b0; run = 1'b1;
    tick(); tick();
    check("unf_stk", stk, 4'b0000);
    check("unf_fault_pre", fault, 1'b0);
    tick();
    check("unf_fault", fault, 1'b1);
    check("unf_halted", halted, 1'b1);
    tick(); tick();
    check("unf_run_ignored", halted, 1'b1);
    check("unf_sticky", fault, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
